// File: rtl/dadda_mul_pipe.sv
// dadda_mul_pipe: 3-stage pipelined unsigned Dadda multiplier with valid/ready handshakes.
//
// Stage 1 registers the operands and the per-beat mode. Stage 2 builds the WIDTH x WIDTH
// partial-product matrix and reduces it to two rows with a Dadda tree of half/full adders.
// Stage 3 adds the two rows with a carry-lookahead adder, truncates to OUT_WIDTH and flags
// overflow when truncation drops nonzero bits.
//
// In approximate mode (approx_en=1 at acceptance) the low APPROX_K product columns are each
// replaced by the OR of their partial products. Carries out of those columns are discarded,
// so the upper columns are built from their own partial products only.
//
// All stages advance together on en = !(out_valid && !out_ready). Bubbles are not compacted.
//
// Ports:
//   clk        clock, all state on the rising edge
//   rst        synchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block accepts a beat this cycle
//   in1, in2   unsigned operands (WIDTH bits)
//   approx_en  mode for this beat: 0 exact, 1 approximate
//   out_valid  result beat valid
//   out_ready  downstream accepts the result
//   out        product truncated to OUT_WIDTH bits
//   overflow   some bit of the 2*WIDTH result at or above OUT_WIDTH is set
module dadda_mul_pipe #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned OUT_WIDTH = 2 * WIDTH,
  parameter int unsigned APPROX_K  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in1,
  input  logic [WIDTH-1:0]     in2,
  input  logic                 approx_en,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out,
  output logic                 overflow
);

  localparam int W    = int'(WIDTH);
  localparam int PW   = 2 * W;
  localparam int K    = int'(APPROX_K);
  // Column heights never exceed the operand width; a little slack keeps indices in range.
  localparam int MAXH = W + 2;

  // Dadda height sequence: d0 = 2, d(j+1) = floor(1.5 * d(j)).
  function automatic int dadda_d(input int j);
    int d;
    d = 2;
    for (int i = 0; i < 32; i++) begin
      if (i < j) d = (d * 3) / 2;
    end
    return d;
  endfunction

  // Number of reduction stages: count of heights strictly below the initial height w.
  function automatic int dadda_stages(input int w);
    int d;
    int n;
    d = 2;
    n = 0;
    for (int i = 0; i < 32; i++) begin
      if (d < w) begin
        n++;
        d = (d * 3) / 2;
      end
    end
    return n;
  endfunction

  localparam int NSTG = dadda_stages(W);

  logic en;

  // Stage 1 state
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;

  // Stage 2 state
  logic          s2_valid;
  logic [PW-1:0] s2_row0;
  logic [PW-1:0] s2_row1;

  // Combinational results
  logic [PW-1:0] row0;
  logic [PW-1:0] row1;
  logic [PW-1:0] sum;
  logic          ovf;

  assign en       = !(out_valid && !out_ready);
  assign in_ready = en;

  // Partial-product generation and Dadda reduction to two rows.
  always_comb begin : reduce
    logic [MAXH-1:0] cur  [PW];
    logic [MAXH-1:0] nxt  [PW];
    int              cnt  [PW];
    int              ncnt [PW];
    int              h;
    int              d;
    int              r;
    int              c;
    logic            x;
    logic            y;
    logic            z;
    logic            orb;

    h   = 0;
    d   = 0;
    r   = 0;
    c   = 0;
    x   = 1'b0;
    y   = 1'b0;
    z   = 1'b0;
    orb = 1'b0;
    for (int col = 0; col < PW; col++) begin
      cur[col]  = '0;
      nxt[col]  = '0;
      cnt[col]  = 0;
      ncnt[col] = 0;
    end

    // In approximate mode the low columns are masked out of the tree, so nothing they
    // contain can carry upward; their final bits are supplied by the OR below.
    for (int i = 0; i < W; i++) begin
      for (int j = 0; j < W; j++) begin
        c = i + j;
        cur[c][cnt[c]] = s1_b[i] & s1_a[j] & !(s1_mode && (c < K));
        cnt[c]++;
      end
    end

    for (int s = NSTG - 1; s >= 0; s--) begin
      d = dadda_d(s);
      for (int col = 0; col < PW; col++) begin
        nxt[col]  = '0;
        ncnt[col] = 0;
      end
      for (int col = 0; col < PW; col++) begin
        r = 0;
        // Height counts untouched bits plus sums and incoming carries of this stage.
        for (int k = 0; k < MAXH; k++) begin
          h = cnt[col] - r + ncnt[col];
          if (h > d) begin
            if (h == d + 1) begin
              x = cur[col][r];
              y = cur[col][r+1];
              nxt[col][ncnt[col]] = x ^ y;
              ncnt[col]++;
              if (col + 1 < PW) begin
                nxt[col+1][ncnt[col+1]] = x & y;
                ncnt[col+1]++;
              end
              r += 2;
            end else begin
              x = cur[col][r];
              y = cur[col][r+1];
              z = cur[col][r+2];
              nxt[col][ncnt[col]] = x ^ y ^ z;
              ncnt[col]++;
              if (col + 1 < PW) begin
                nxt[col+1][ncnt[col+1]] = (x & y) | (x & z) | (y & z);
                ncnt[col+1]++;
              end
              r += 3;
            end
          end
        end
        for (int k = 0; k < MAXH; k++) begin
          if (k >= r && k < cnt[col]) begin
            nxt[col][ncnt[col]] = cur[col][k];
            ncnt[col]++;
          end
        end
      end
      for (int col = 0; col < PW; col++) begin
        cur[col] = nxt[col];
        cnt[col] = ncnt[col];
      end
    end

    for (int col = 0; col < PW; col++) begin
      row0[col] = cur[col][0];
      row1[col] = cur[col][1];
    end

    // Approximate low columns: single OR bit each, nothing in the second row.
    for (int col = 0; col < PW; col++) begin
      if (col < K) begin
        orb = 1'b0;
        for (int i = 0; i < W; i++) begin
          for (int j = 0; j < W; j++) begin
            if (i + j == col) orb = orb | (s1_b[i] & s1_a[j]);
          end
        end
        if (s1_mode) begin
          row0[col] = orb;
          row1[col] = 1'b0;
        end
      end
    end
  end

  // Final adder: 4-bit lookahead groups, group carries chained; carry-in is zero.
  always_comb begin : cla_w
    logic [PW-1:0] g;
    logic [PW-1:0] p;
    logic [PW-1:0] cy;
    logic          acc_p;
    logic          carry;
    int            base;

    g     = s2_row0 & s2_row1;
    p     = s2_row0 ^ s2_row1;
    cy    = '0;
    acc_p = 1'b0;
    carry = 1'b0;
    base  = 0;
    for (int b = 0; b < PW - 1; b++) begin
      base  = (b / 4) * 4;
      acc_p = 1'b1;
      carry = 1'b0;
      for (int k = 0; k < 4; k++) begin
        if (b - k >= base) begin
          carry = carry | (acc_p & g[b-k]);
          acc_p = acc_p & p[b-k];
        end
      end
      cy[b+1] = carry | (acc_p & cy[base]);
    end
    sum = p ^ cy;
  end

  if (OUT_WIDTH < 2 * WIDTH) begin : g_ovf
    assign ovf = |sum[PW-1:OUT_WIDTH];
  end else begin : g_no_ovf
    assign ovf = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_a      <= '0;
      s1_b      <= '0;
      s1_mode   <= 1'b0;
      s2_valid  <= 1'b0;
      s2_row0   <= '0;
      s2_row1   <= '0;
      out_valid <= 1'b0;
      out       <= '0;
      overflow  <= 1'b0;
    end else if (en) begin
      s1_valid  <= in_valid;
      s2_valid  <= s1_valid;
      out_valid <= s2_valid;
      if (in_valid) begin
        s1_a    <= in1;
        s1_b    <= in2;
        s1_mode <= approx_en;
      end
      if (s1_valid) begin
        s2_row0 <= row0;
        s2_row1 <= row1;
      end
      // Result registers only move on a real beat so they hold across bubbles.
      if (s2_valid) begin
        out      <= sum[OUT_WIDTH-1:0];
        overflow <= ovf;
      end
    end
  end

endmodule
